baud_dezimierer: RTL and testbench
==================================

BAUD_DEZIMIERER -- requirements
Module: baud_dezimierer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the prescaler counter and of div_val.
REQ-002 Parameter OS_FACTOR, default 16: tick_os pulses per baud period; SHALL be even and >= 2.
REQ-003 Parameter DIV_DEFAULT, default 27: clk cycles per tick_os after reset.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  counting enable; counters hold while low.
REQ-007 restart  input  1  synchronous phase realignment, one-cycle pulse.
REQ-008 load  input  1  latches div_val into the pending-divisor register.
REQ-009 div_val  input  CNT_WIDTH  requested clk cycles per tick_os.
REQ-010 tick_os  output  1  registered one-cycle oversample strobe.
REQ-011 tick_baud  output  1  registered one-cycle baud strobe.
REQ-012 clk_dez  output  1  registered 50 % duty decimated clock, period OS_FACTOR*div cycles.
REQ-013 os_index  output  $clog2(OS_FACTOR)  current oversample position, 0..OS_FACTOR-1.

Function
REQ-014 Two divisor registers SHALL exist: div_pend (written by load) and div_act (used by the counter); an effective divisor of 0 SHALL be treated as 1.
REQ-015 load=1 SHALL write div_val into div_pend at the next edge; div_act SHALL copy div_pend only at a prescaler wrap or on restart, never mid-period.
REQ-016 load and a wrap in the same cycle: the wrap SHALL copy the old div_pend; the new value applies from the following wrap.
REQ-017 Prescaler cnt (CNT_WIDTH bits): with enable=1, cnt < div_act-1 -> cnt+1; cnt = div_act-1 -> cnt <= 0 and a tick event occurs.
REQ-018 tick_os SHALL be 1 in the cycle following a tick event, else 0; tick_os period equals div_act cycles; div_act=1 gives tick_os constantly 1.
REQ-019 os_index SHALL advance by 1 on each tick event, wrapping OS_FACTOR-1 -> 0.
REQ-020 tick_baud SHALL be 1 in exactly the cycle where tick_os=1 and os_index has just wrapped to 0.
REQ-021 clk_dez SHALL toggle on tick events at which os_index leaves OS_FACTOR/2-1 or OS_FACTOR-1.
REQ-022 enable=0: cnt, os_index, clk_dez hold; tick_os and tick_baud are 0 from the next edge; counting resumes from the held value.
REQ-023 restart=1 (priority over enable and load): cnt<=0, os_index<=0, clk_dez<=0, tick_os<=0, tick_baud<=0, div_act<=div_pend; if load is also 1, div_pend and div_act both take div_val.
REQ-024 cnt SHALL never exceed div_act-1; if div_act drops below cnt+1, the next edge SHALL treat it as a wrap.

Reset
REQ-025 reset_n=0 SHALL immediately force cnt=0, os_index=0, tick_os=0, tick_baud=0, clk_dez=0, div_pend=div_act=DIV_DEFAULT.
REQ-026 Reset deassertion SHALL be sampled synchronously; first counting edge is the first rising clk edge with reset_n=1 and enable=1.
REQ-027 Reset asserted mid-period SHALL abort the period with no residual tick pulse.

Verification
REQ-028 DIV_DEFAULT=4, OS_FACTOR=4, enable=1 after reset -> tick_os high on cycles 4,8,12,...; tick_baud on cycle 16,32; clk_dez toggles at 8,16 (period 16).
REQ-029 load with div_val=2 at cycle 5 (same config) -> div_act stays 4 until the wrap at cycle 8; tick_os then at 10,12,14.
REQ-030 div_val=0 loaded then restart -> tick_os=1 every cycle from the second edge after restart; tick_baud every 4th cycle.
REQ-031 enable low for 7 cycles at cnt=2 -> no ticks, os_index and clk_dez frozen; next tick_os 2 cycles after enable returns.
REQ-032 restart at os_index=3, clk_dez=1 -> next cycle all outputs 0; tick_baud 16 cycles later (DIV=4, OS=4).
REQ-033 reset_n pulsed low mid-period (asynchronous, between edges) -> outputs 0 before the next edge; sequence of REQ-028 restarts from cycle 0.

Source files
------------

// File: rtl/baud_dezimierer.sv
`default_nettype none
// ============================================================================
// Module      : baud_dezimierer
// Description : Programmable baud-rate prescaler producing an oversample
//               strobe, a baud strobe, an oversample index and a 50 % duty
//               decimated clock.
// Revision    : 1.0 - initial release
// ============================================================================

module baud_dezimierer #(
    parameter int CNT_WIDTH   = 16,
    parameter int OS_FACTOR   = 16,
    parameter int DIV_DEFAULT = 27
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         restart,
    input  logic                         load,
    input  logic [CNT_WIDTH-1:0]         div_val,
    output logic                         tick_os,
    output logic                         tick_baud,
    output logic                         clk_dez,
    output logic [$clog2(OS_FACTOR)-1:0] os_index
);

    localparam int                   OS_W      = $clog2(OS_FACTOR);
    localparam logic [OS_W-1:0]      c_OS_LAST = OS_W'(OS_FACTOR - 1);
    localparam logic [OS_W-1:0]      c_OS_HALF = OS_W'(OS_FACTOR / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] c_DIV_RST = CNT_WIDTH'(DIV_DEFAULT);
    localparam logic [CNT_WIDTH-1:0] c_ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_div_pend;
    logic [CNT_WIDTH-1:0] r_div_act;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [OS_W-1:0]      r_os_index;
    logic                 r_tick_os;
    logic                 r_tick_baud;
    logic                 r_clk_dez;

    logic [CNT_WIDTH-1:0] w_div_eff;
    logic [CNT_WIDTH-1:0] w_cnt_last;
    logic                 w_wrap;
    logic [OS_W-1:0]      w_os_next;
    logic                 w_dez_flip;

    // A zero divisor behaves as one; ">=" also catches a divisor that shrank
    // below the running count, so the counter can never run past its period.
    always_comb begin
        w_div_eff  = (r_div_act == '0) ? c_ONE : r_div_act;
        w_cnt_last = w_div_eff - c_ONE;
        w_wrap     = enable && (r_cnt >= w_cnt_last);
        w_os_next  = (r_os_index == c_OS_LAST) ? '0 : r_os_index + 1'b1;
        w_dez_flip = (r_os_index == c_OS_HALF) || (r_os_index == c_OS_LAST);
    end

    // Pending divisor is written by load; the active one only changes at a
    // period boundary (wrap or restart), taking the pre-load pending value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_pend <= c_DIV_RST;
            r_div_act  <= c_DIV_RST;
        end else if (restart) begin
            r_div_pend <= load ? div_val : r_div_pend;
            r_div_act  <= load ? div_val : r_div_pend;
        end else begin
            if (load) begin
                r_div_pend <= div_val;
            end
            if (w_wrap) begin
                r_div_act <= r_div_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + c_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_os_index  <= '0;
            r_clk_dez   <= 1'b0;
            r_tick_os   <= 1'b0;
            r_tick_baud <= 1'b0;
        end else if (restart) begin
            r_os_index  <= '0;
            r_clk_dez   <= 1'b0;
            r_tick_os   <= 1'b0;
            r_tick_baud <= 1'b0;
        end else begin
            r_tick_os   <= w_wrap;
            r_tick_baud <= w_wrap && (w_os_next == '0);
            if (w_wrap) begin
                r_os_index <= w_os_next;
                if (w_dez_flip) begin
                    r_clk_dez <= ~r_clk_dez;
                end
            end
        end
    end

    assign tick_os   = r_tick_os;
    assign tick_baud = r_tick_baud;
    assign clk_dez   = r_clk_dez;
    assign os_index  = r_os_index;

endmodule

`default_nettype wire

// File: tb/tb_baud_dezimierer.sv
`default_nettype none
// ============================================================================
// Module      : tb_baud_dezimierer
// Description : Directed self-checking bench for baud_dezimierer
//               (DIV_DEFAULT=4, OS_FACTOR=4).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_baud_dezimierer;

    localparam int CNT_WIDTH = 16;
    localparam int OS_FACTOR = 4;
    localparam int DIV_DEF   = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 enable;
    logic                 restart;
    logic                 load;
    logic [CNT_WIDTH-1:0] div_val;
    logic                 tick_os;
    logic                 tick_baud;
    logic                 clk_dez;
    logic [1:0]           os_index;

    int n_checks;
    int n_errors;

    baud_dezimierer #(
        .CNT_WIDTH  (CNT_WIDTH),
        .OS_FACTOR  (OS_FACTOR),
        .DIV_DEFAULT(DIV_DEF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .restart  (restart),
        .load     (load),
        .div_val  (div_val),
        .tick_os  (tick_os),
        .tick_baud(tick_baud),
        .clk_dez  (clk_dez),
        .os_index (os_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int n, input int e_tick, input int e_baud,
                           input int e_os, input int e_dez);
        chk($sformatf("%s c%0d tick_os", tag, n), 32'(tick_os), 32'(e_tick));
        chk($sformatf("%s c%0d tick_baud", tag, n), 32'(tick_baud), 32'(e_baud));
        chk($sformatf("%s c%0d os_index", tag, n), 32'(os_index), 32'(e_os));
        chk($sformatf("%s c%0d clk_dez", tag, n), 32'(clk_dez), 32'(e_dez));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steady counting with divisor d: tick every d cycles, baud every 4*d,
    // clk_dez toggling every 2*d cycles.
    task automatic run_seq(input string tag, input int d, input int n_first, input int n_last);
        for (int n = n_first; n <= n_last; n++) begin
            step();
            chk_all(tag, n, int'(n % d == 0), int'(n % (4 * d) == 0),
                    (n / d) % 4, (n / (2 * d)) % 2);
        end
    endtask

    logic [15:0] t_tick;
    logic [15:0] t_baud;
    logic [15:0] t_dez;
    int          t_os [16];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        enable   = 1'b1;
        restart  = 1'b0;
        load     = 1'b0;
        div_val  = '0;

        // Reset state and the basic default-divisor sequence
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        run_seq("default", 4, 1, 44);

        // Asynchronous reset between edges at os_index=3, clk_dez=1
        #2 reset_n = 1'b0;
        #1 chk_all("async_rst", 44, 0, 0, 0, 0);
        step();
        chk_all("rst_hold", 45, 0, 0, 0, 0);
        reset_n = 1'b1;
        run_seq("after_rst", 4, 1, 16);

        // Load div=2 at cycle 5; new divisor only from the wrap at cycle 8
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        t_tick = 16'b1010_1010_1000_1000;
        t_baud = 16'h0800;
        t_dez  = 16'h8780;
        t_os   = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2};
        for (int n = 1; n <= 16; n++) begin
            if (n == 5) begin
                load    = 1'b1;
                div_val = 16'd2;
            end
            step();
            load = 1'b0;
            chk_all("load2", n, int'(t_tick[n-1]), int'(t_baud[n-1]), t_os[n-1],
                    int'(t_dez[n-1]));
        end

        // Restart with simultaneous load of 4
        restart = 1'b1;
        load    = 1'b1;
        div_val = 16'd4;
        step();
        restart = 1'b0;
        load    = 1'b0;
        chk_all("restart_load", 0, 0, 0, 0, 0);
        run_seq("div4", 4, 1, 14);

        // Enable low for 7 cycles with cnt=2, os_index=3, clk_dez=1
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_all("hold", i, 0, 0, 3, 1);
        end
        enable = 1'b1;
        step();
        chk_all("resume", 15, 0, 0, 3, 1);
        step();
        chk_all("resume", 16, 1, 1, 0, 0);
        run_seq("resume_run", 4, 17, 28);

        // Restart at os_index=3, clk_dez=1
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk_all("restart", 0, 0, 0, 0, 0);
        run_seq("post_restart", 4, 1, 16);

        // Divisor 0 behaves as 1 after restart
        load    = 1'b1;
        div_val = 16'd0;
        step();
        load = 1'b0;
        chk_all("load0", 17, 0, 0, 0, 0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk_all("restart0", 0, 0, 0, 0, 0);
        run_seq("div0", 1, 1, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
